// File: rtl/prio_encoder_hs_pkg.sv
// Shared constants, types and helpers for the handshaked priority encoder.
package prio_encoder_hs_pkg;

  // Default number of request lines.
  localparam int unsigned DefaultN = 4;

  // Widest request vector the onehot() helper can represent.
  localparam int unsigned MaxN    = 64;
  localparam int unsigned MaxIdxW = 6;

  // Two-state view of the output register: empty or holding a grant.
  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StHold = 1'b1
  } state_e;

  // Index width for n request lines; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // Same mapping as the binary-to-one-hot decoder: index k -> bit k.
  function automatic logic [MaxN-1:0] onehot(input logic [MaxIdxW-1:0] idx);
    logic [MaxN-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/prio_enc_comb.sv
// Combinational priority search: first set bit of cand at or above start,
// wrapping from N-1 back to 0. With start tied to 0 this is plain
// lowest-index-first priority.
module prio_enc_comb #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 2
) (
  input  logic [N-1:0] cand,
  input  logic [W-1:0] start,
  output logic [W-1:0] idx,
  output logic         any
);

  localparam logic [W:0] NVal = (W + 1)'(N);

  logic [N-1:0] rot;
  logic [W-1:0] off;
  logic [W:0]   sum;

  // Rotate so start lands at bit 0, find lowest set bit, then map back.
  always_comb begin
    rot = N'({cand, cand} >> start);
    any = 1'b0;
    off = '0;
    for (int i = 0; i < N; i++) begin
      if (!any && rot[i]) begin
        any = 1'b1;
        off = W'(i);
      end
    end
    sum = {1'b0, start} + {1'b0, off};
    if (sum >= NVal) begin
      sum = sum - NVal;
    end
    idx = sum[W-1:0];
  end

endmodule

// File: rtl/prio_encoder_hs.sv
// Handshaked priority encoder: collects request pulses into a sticky pending
// vector and hands out one binary index per valid/ready handshake.
// Define PRIO_ENC_RR_EN for rotating priority; otherwise the lowest pending
// index always wins.
module prio_encoder_hs
  import prio_encoder_hs_pkg::*;
#(
  parameter int unsigned N = DefaultN,
  parameter int unsigned W = idx_width(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] pending_out,
  output logic         busy
);

  state_e       state_q, state_d;
  logic [W-1:0] idx_q, idx_d;
  logic [N-1:0] pend_q, pend_d;

  logic [N-1:0] cand;
  logic [N-1:0] grant_oh;
  logic         load;
  logic         enc_any;
  logic [W-1:0] enc_idx;
  logic [W-1:0] enc_start;

  // New requests bypass the pending register so a pulse is granted next cycle.
  assign cand     = pend_q | req_in;
  assign load     = (state_q == StIdle) || out_ready;
  assign grant_oh = N'(onehot(MaxIdxW'(enc_idx)));

`ifdef PRIO_ENC_RR_EN
  localparam logic [W-1:0] LastIdx = W'(N - 1);

  logic [W-1:0] rr_q, rr_d;

  // Search starts just above the most recent grant.
  always_comb begin
    rr_d = rr_q;
    if (load && enc_any) begin
      rr_d = (enc_idx == LastIdx) ? '0 : enc_idx + 1'b1;
    end
  end

  // Rotation pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q <= '0;
    end else begin
      rr_q <= rr_d;
    end
  end

  assign enc_start = rr_q;
`else
  assign enc_start = '0;
`endif

  prio_enc_comb #(
    .N(N),
    .W(W)
  ) u_enc (
    .cand (cand),
    .start(enc_start),
    .idx  (enc_idx),
    .any  (enc_any)
  );

  // Output register reloads when empty or accepted; a stall only accumulates.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pend_d  = pend_q;
    if (load) begin
      if (enc_any) begin
        state_d = StHold;
        idx_d   = enc_idx;
        pend_d  = cand & ~grant_oh;
      end else begin
        state_d = StIdle;
        pend_d  = '0;
      end
    end else begin
      // Includes a re-request of the held index, so it is served again later.
      pend_d = cand;
    end
  end

  // State, index and pending registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
    end
  end

  assign out_valid   = (state_q == StHold);
  assign out_idx     = idx_q;
  assign pending_out = pend_q;
  assign busy        = out_valid | (|pend_q);

endmodule
